// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: blanking constants, the digit word type
// and glyphs used by the pattern generators feeding the scan driver.
package seg7_pkg;

    // Active-low: all ones means every segment / digit is dark.
    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [3:0] DIGIT_OFF = 4'b1111;

    // One digit as carried on the data_N inputs: {dot, seg[6:0]}, active-low.
    typedef struct packed {
        logic       dot;
        logic [6:0] seg;
    } seg_word_t;

    localparam seg_word_t WORD_OFF = '{dot: 1'b1, seg: SEG_OFF};

    // Glyphs for the circle-sequence animator (seg order {g,f,e,d,c,b,a}).
    localparam logic [6:0] UP_CIRCLE   = 7'b0011100;
    localparam logic [6:0] DOWN_CIRCLE = 7'b0100011;

    // Hexadecimal digit glyphs, active-low, seg order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_glyph(input logic [3:0] value);
        logic [6:0] glyph;
        case (value)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h08;
            4'hB:    glyph = 7'h03;
            4'hC:    glyph = 7'h46;
            4'hD:    glyph = 7'h21;
            4'hE:    glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-digit slot timer: modulo-SLOT_CYCLES counter, cleared while the scan is
// disabled, flagging the slot boundary (wrap cycle) and the blanking window.
module seg7_slot_timer #(
    parameter  int SLOT_CYCLES  = 10,
    parameter  int BLANK_CYCLES = 2,
    localparam int CNT_W        = $clog2(SLOT_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] slot_cnt,
    output logic             boundary,
    output logic             blank
);

    // A slot needs room for at least one lit cycle after the blanking window.
    generate
        if (SLOT_CYCLES < 2) begin : g_bad_slot
            $error("seg7_slot_timer: SLOT_CYCLES must be >= 2");
        end
        if (BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad_blank
            $error("seg7_slot_timer: BLANK_CYCLES must be < SLOT_CYCLES");
        end
    endgenerate

    assign boundary = en && (slot_cnt == CNT_W'(SLOT_CYCLES - 1));
    assign blank    = (slot_cnt < CNT_W'(BLANK_CYCLES));

    // Slot counter: wraps at the boundary, held at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt <= '0;
        end else if (!en || boundary) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit seven-segment scan driver. Time-multiplexes four active-low digit
// words onto the shared segment bus with a blanking gap before each digit,
// latching each word at its slot boundary, and pulses frame_tick per frame.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int FPGA_FREQ    = 50_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] data_0,
    input  logic [7:0] data_1,
    input  logic [7:0] data_2,
    input  logic [7:0] data_3,
    output logic [3:0] LED_enables,
    output logic [6:0] LED_7SEG,
    output logic       LED_dot,
    output logic       frame_tick
);

    localparam int SLOT_CYCLES = FPGA_FREQ / (REFRESH_HZ * 4);
    localparam int CNT_W       = $clog2(SLOT_CYCLES);

    logic [CNT_W-1:0] slot_cnt;
    logic             boundary;
    logic             blank;
    logic [1:0]       idx;
    logic [1:0]       idx_next;
    seg_word_t        latch;
    seg_word_t        next_word;

    seg7_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .slot_cnt (slot_cnt),
        .boundary (boundary),
        .blank    (blank)
    );

    assign idx_next = idx + 2'd1;

    // Select the word of the digit whose slot starts at the next boundary.
    always_comb begin
        next_word = data_0;
        case (idx_next)
            2'd0:    next_word = data_0;
            2'd1:    next_word = data_1;
            2'd2:    next_word = data_2;
            default: next_word = data_3;
        endcase
    end

    // Digit index and word latch advance together at each slot boundary;
    // while disabled they park on digit 0 so re-enable starts a clean frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= 2'd0;
            latch <= WORD_OFF;
        end else if (!en) begin
            idx   <= 2'd0;
            latch <= data_0;
        end else if (boundary) begin
            idx   <= idx_next;
            latch <= next_word;
        end
    end

    // Registered pin drivers: dark during blanking or when disabled, otherwise
    // one enable low for the current digit. Because blanking sits at the start
    // of every slot, two enables can never be low together across idx changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            LED_enables <= DIGIT_OFF;
            LED_7SEG    <= SEG_OFF;
            LED_dot     <= 1'b1;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick <= boundary && (idx == 2'd3);
            if (!en || blank) begin
                LED_enables <= DIGIT_OFF;
                LED_7SEG    <= SEG_OFF;
                LED_dot     <= 1'b1;
            end else begin
                LED_enables <= ~(4'b0001 << idx);
                LED_7SEG    <= latch.seg;
                LED_dot     <= latch.dot;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 10-cycle slot and 2-cycle blank.
module tb_seg7_scan_driver;
    import seg7_pkg::*;

    localparam int FPGA_FREQ  = 400;
    localparam int REFRESH_HZ = 10;
    localparam int BLANK      = 2;
    localparam int SLOT       = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] data_0, data_1, data_2, data_3;
    logic [3:0] LED_enables;
    logic [6:0] LED_7SEG;
    logic       LED_dot;
    logic       frame_tick;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_word [4];
    int         last_cnt = 0;

    seg7_scan_driver #(
        .FPGA_FREQ    (FPGA_FREQ),
        .REFRESH_HZ   (REFRESH_HZ),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .data_0      (data_0),
        .data_1      (data_1),
        .data_2      (data_2),
        .data_3      (data_3),
        .LED_enables (LED_enables),
        .LED_7SEG    (LED_7SEG),
        .LED_dot     (LED_dot),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int n, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s step %0d got %h exp %h", tag, n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dark(input string tag, input int n);
        chk({tag, "_en"}, n, {4'b0, LED_enables}, {4'b0, DIGIT_OFF});
        chk({tag, "_word"}, n, {LED_dot, LED_7SEG}, 8'hFF);
        chk({tag, "_tick"}, n, {7'b0, frame_tick}, 8'h00);
    endtask

    // Step n counts clock edges since scanning (re)started; outputs after edge n
    // reflect slot position (n-1) because of the one-clock output register.
    task automatic check_scan(input int n);
        int         k;
        int         p;
        logic [3:0] en_exp;
        k = (n - 1) / SLOT;
        p = (n - 1) % SLOT;
        if (p < BLANK) begin
            chk("blank_en", n, {4'b0, LED_enables}, 8'h0F);
            chk("blank_word", n, {LED_dot, LED_7SEG}, 8'hFF);
        end else begin
            en_exp = 4'b0001 << (k % 4);
            en_exp = ~en_exp;
            chk("lit_en", n, {4'b0, LED_enables}, {4'b0, en_exp});
            chk("lit_word", n, {LED_dot, LED_7SEG}, exp_word[k % 4]);
        end
        chk("tick", n, {7'b0, frame_tick}, (n % 40 == 0) ? 8'h01 : 8'h00);
    endtask

    task automatic scan(input int first, input int last);
        for (int n = first; n <= last; n++) begin
            step();
            check_scan(n);
        end
    endtask

    // Invariants at every clock: at most one digit lit, and dark whenever the
    // slot position driving the current outputs was inside the blank window.
    always @(negedge clk) begin
        checks++;
        assert ($countones(~LED_enables) <= 1) else begin
            errors++;
            $error("FAIL onehot got %b exp at most one low", LED_enables);
        end
        if (last_cnt < BLANK) begin
            checks++;
            assert (LED_enables === 4'b1111) else begin
                errors++;
                $error("FAIL blank_inv got %b exp 1111 (cnt %0d)", LED_enables, last_cnt);
            end
        end
        last_cnt = int'(dut.slot_cnt);
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        data_0 = 8'hFE;
        data_1 = 8'hFD;
        data_2 = 8'hFB;
        data_3 = 8'hF7;
        exp_word[0] = 8'hFE;
        exp_word[1] = 8'hFD;
        exp_word[2] = 8'hFB;
        exp_word[3] = 8'hF7;

        // Reset state
        step();
        chk_dark("reset", 0);
        rst = 1'b0;
        step();
        chk_dark("idle", 0);
        step();
        en = 1'b1;

        // Full scan with frame ticks, then data_1 changed mid lit phase
        scan(1, 96);
        data_1 = 8'h80;
        scan(97, 100);
        exp_word[1] = 8'h80;
        scan(101, 145);

        // Disable mid digit-2 slot, dark for 5 clocks, then re-enable
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_dark("en_off", 146 + i);
        end
        en = 1'b1;
        scan(1, 75);

        // Async reset mid digit-3 lit phase
        rst = 1'b1;
        #1;
        chk_dark("async_rst", 75);
        step();
        chk_dark("rst_hold", 76);
        rst = 1'b0;
        exp_word[0] = 8'hFF;
        scan(1, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
